// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, decoder-facing outputs and
// redirect/stall controls.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] inst_out;
  logic [15:0] pc_plus2_out;
  logic        inst_valid;
  logic        halted;

  modport master (
    output imem_req, imem_addr, inst_out, pc_plus2_out, inst_valid, halted,
    input  imem_rdata, imem_ready, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_out, pc_plus2_out, inst_valid, halted,
    output imem_rdata, imem_ready, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, variable-latency imem handshake, output register with
// one-entry skid buffer, redirect flush and halt detection.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = 5'b00000
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] req_addr_r, req_addr_s;
  logic        out_valid_r, out_valid_s;
  logic [15:0] out_inst_r, out_inst_s;
  logic [15:0] out_pc2_r, out_pc2_s;
  logic        skid_valid_r, skid_valid_s;
  logic [15:0] skid_inst_r, skid_inst_s;
  logic [15:0] skid_pc2_r, skid_pc2_s;

  logic        req_s;
  logic [15:0] addr_s;
  logic [15:0] pc_inc_s;
  logic        accept_s;
  logic        out_free_s;

  // Next-state, buffer movement and memory request generation
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_addr_s   = req_addr_r;
    out_valid_s  = out_valid_r;
    out_inst_s   = out_inst_r;
    out_pc2_s    = out_pc2_r;
    skid_valid_s = skid_valid_r;
    skid_inst_s  = skid_inst_r;
    skid_pc2_s   = skid_pc2_r;
    req_s        = 1'b0;
    addr_s       = pc_r;
    pc_inc_s     = pc_r + 16'd2;

    case (state_r)
      FETCH: begin
        req_s  = !skid_valid_r;
        addr_s = pc_r;
      end
      DISCARD: begin
        // A request already in flight must complete at its original address
        req_s  = 1'b1;
        addr_s = req_addr_r;
      end
      HALTED: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
    endcase

    accept_s   = (state_r == FETCH) && req_s && bus.imem_ready && !bus.redirect_valid;
    out_free_s = !out_valid_r || !bus.stall;

    if (bus.redirect_valid) begin
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
      pc_s         = bus.redirect_pc;
      if (req_s && !bus.imem_ready) begin
        state_s    = DISCARD;
        req_addr_s = addr_s;
      end else begin
        state_s    = FETCH;
      end
    end else begin
      if (out_free_s) begin
        if (skid_valid_r) begin
          out_valid_s  = 1'b1;
          out_inst_s   = skid_inst_r;
          out_pc2_s    = skid_pc2_r;
          skid_valid_s = 1'b0;
        end else begin
          out_valid_s  = 1'b0;
        end
      end else begin
        out_valid_s = out_valid_r;
      end

      if (accept_s) begin
        pc_s = pc_inc_s;
        if (out_free_s && !skid_valid_r) begin
          out_valid_s = 1'b1;
          out_inst_s  = bus.imem_rdata;
          out_pc2_s   = pc_inc_s;
        end else begin
          skid_valid_s = 1'b1;
          skid_inst_s  = bus.imem_rdata;
          skid_pc2_s   = pc_inc_s;
        end
        if (bus.imem_rdata[15:11] == HALT_OP) begin
          state_s = HALTED;
        end else begin
          state_s = FETCH;
        end
      end else if ((state_r == DISCARD) && bus.imem_ready) begin
        state_s = FETCH;
      end else begin
        state_s = state_r;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      out_valid_r  <= 1'b0;
      out_inst_r   <= 16'h0000;
      out_pc2_r    <= 16'h0000;
      skid_valid_r <= 1'b0;
      skid_inst_r  <= 16'h0000;
      skid_pc2_r   <= 16'h0000;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_addr_r   <= req_addr_s;
      out_valid_r  <= out_valid_s;
      out_inst_r   <= out_inst_s;
      out_pc2_r    <= out_pc2_s;
      skid_valid_r <= skid_valid_s;
      skid_inst_r  <= skid_inst_s;
      skid_pc2_r   <= skid_pc2_s;
    end
  end

  assign bus.imem_req     = req_s;
  assign bus.imem_addr    = addr_s;
  assign bus.inst_out     = out_inst_r;
  assign bus.pc_plus2_out = out_pc2_r;
  assign bus.inst_valid   = out_valid_r;
  assign bus.halted       = (state_r == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency,
// hand-computed expectations for each scenario.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] mem [0:255];
  int          lat_m1   = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OP(5'b00000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory answers once a request has been held for lat_m1 cycles
  always_comb bus.imem_ready = bus.imem_req && (wait_cnt >= lat_m1);
  always_comb bus.imem_rdata = mem[bus.imem_addr[8:1]];

  always_ff @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = {8'hA0, i[7:0]};
    mem[0] = 16'h4101;
    mem[1] = 16'h4202;
    mem[2] = 16'h4303;
    mem[3] = 16'h4404;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [15:0] exp_inst [0:3];

  initial begin
    exp_inst[0] = 16'h4101;
    exp_inst[1] = 16'h4202;
    exp_inst[2] = 16'h4303;
    exp_inst[3] = 16'h4404;

    // Reset state
    init_mem();
    lat_m1 = 0;
    do_reset();
    check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, bus.halted}, 32'd0);
    check_eq("rst_inst", {16'd0, bus.inst_out}, 32'h0000);
    check_eq("rst_pc2", {16'd0, bus.pc_plus2_out}, 32'h0000);
    check_eq("rst_addr", {16'd0, bus.imem_addr}, 32'h0000);
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd1);

    // 1: zero-wait streaming
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("zw_valid", {31'd0, bus.inst_valid}, 32'd1);
      check_eq("zw_inst", {16'd0, bus.inst_out}, {16'd0, exp_inst[c]});
      check_eq("zw_pc2", {16'd0, bus.pc_plus2_out}, 32'(2 * (c + 1)));
    end

    // 2: three-cycle latency
    lat_m1 = 2;
    do_reset();
    check_eq("lat_addr0", {16'd0, bus.imem_addr}, 32'h0000);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c % 3 == 0) begin
        check_eq("lat_valid", {31'd0, bus.inst_valid}, 32'd1);
        check_eq("lat_inst", {16'd0, bus.inst_out}, {16'd0, exp_inst[c / 3 - 1]});
        check_eq("lat_pc2", {16'd0, bus.pc_plus2_out}, 32'(2 * (c / 3)));
      end else begin
        check_eq("lat_gap", {31'd0, bus.inst_valid}, 32'd0);
      end
      if (c < 3) check_eq("lat_addr_hold", {16'd0, bus.imem_addr}, 32'h0000);
    end

    // 3: stall with skid capture, then release
    lat_m1 = 0;
    do_reset();
    bus.stall = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq("stl_valid", {31'd0, bus.inst_valid}, 32'd1);
      check_eq("stl_inst", {16'd0, bus.inst_out}, 32'h4101);
      if (c >= 2) check_eq("stl_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.stall = 1'b0;
    step();
    check_eq("rel_inst1", {16'd0, bus.inst_out}, 32'h4202);
    check_eq("rel_valid1", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("rel_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("rel_addr", {16'd0, bus.imem_addr}, 32'h0004);
    step();
    check_eq("rel_inst2", {16'd0, bus.inst_out}, 32'h4303);
    check_eq("rel_valid2", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("rel_pc2", {16'd0, bus.pc_plus2_out}, 32'h0006);

    // 6: reset while stalled with the skid full
    do_reset();
    bus.stall = 1'b1;
    step();
    step();
    step();
    check_eq("rs_skid_full", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.stall = 1'b0;
    check_eq("rs_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("rs_halted", {31'd0, bus.halted}, 32'd0);
    check_eq("rs_addr", {16'd0, bus.imem_addr}, 32'h0000);
    check_eq("rs_inst", {16'd0, bus.inst_out}, 32'h0000);

    // 4: redirect while a slow request is outstanding
    lat_m1 = 2;
    do_reset();
    for (int c = 0; c < 7; c++) step();
    check_eq("rd_pre_addr", {16'd0, bus.imem_addr}, 32'h0004);
    check_eq("rd_pre_ready", {31'd0, bus.imem_ready}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("rd_disc_addr", {16'd0, bus.imem_addr}, 32'h0004);
    check_eq("rd_disc_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("rd_disc_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    check_eq("rd_new_addr", {16'd0, bus.imem_addr}, 32'h0100);
    check_eq("rd_drop_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    check_eq("rd_wait1", {31'd0, bus.inst_valid}, 32'd0);
    step();
    check_eq("rd_wait2", {31'd0, bus.inst_valid}, 32'd0);
    step();
    check_eq("rd_valid", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("rd_pc2", {16'd0, bus.pc_plus2_out}, 32'h0102);
    check_eq("rd_inst", {16'd0, bus.inst_out}, 32'h0000A080);

    // 5: halt opcode at 0x0006, then redirect out of HALTED
    init_mem();
    mem[3] = 16'h0000;
    lat_m1 = 0;
    do_reset();
    step();
    step();
    step();
    step();
    check_eq("hl_inst", {16'd0, bus.inst_out}, 32'h0000);
    check_eq("hl_pc2", {16'd0, bus.pc_plus2_out}, 32'h0008);
    check_eq("hl_valid", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("hl_halted", {31'd0, bus.halted}, 32'd1);
    check_eq("hl_req", {31'd0, bus.imem_req}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("hl_hold_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("hl_hold_halted", {31'd0, bus.halted}, 32'd1);
      check_eq("hl_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0020;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("hr_halted", {31'd0, bus.halted}, 32'd0);
    check_eq("hr_addr", {16'd0, bus.imem_addr}, 32'h0020);
    check_eq("hr_req", {31'd0, bus.imem_req}, 32'd1);
    step();
    check_eq("hr_valid", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("hr_inst", {16'd0, bus.inst_out}, 32'h0000A010);
    check_eq("hr_pc2", {16'd0, bus.pc_plus2_out}, 32'h0022);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage feeding the instruction decoder. Holds the PC and issues 16-bit instruction reads to a variable-latency instruction memory with a req/ready handshake. Presents fetched instructions with a valid flag and PC+2 in a front-end register backed by a one-entry skid buffer. Also handles decode stalls, PC redirects from branch/jump resolution, and halt detection.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OP, 5'b00000, opcode in inst[15:11] that stops fetching.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
imem_req  out  1  instruction read request; held until imem_ready
imem_addr  out  16  byte address of request; stable while imem_req high
imem_rdata  in  16  instruction word, valid when imem_ready=1
imem_ready  in  1  memory completes outstanding request this cycle; may assert in the same cycle as imem_req
stall  in  1  decode cannot accept inst_out this cycle
redirect_valid  in  1  load new PC, flush all fetched-but-unconsumed instructions
redirect_pc  in  16  redirect target
inst_out  out  16  instruction to decoder
pc_plus2_out  out  16  address of inst_out + 2
inst_valid  out  1  inst_out/pc_plus2_out valid; consumed when inst_valid && !stall
halted  out  1  fetch stopped after a HALT_OP instruction

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, inst_valid=0, skid valid=0, inst_out=16'h0000, pc_plus2_out=16'h0000, halted=0. rst overrides every other input, including mid-transaction; the memory side tolerates a dropped request.
- States: FETCH, DISCARD, HALTED. halted=1 iff state==HALTED.
- FETCH:
  - imem_req = !skid_valid; imem_addr = pc.
  - pc changes only on imem_ready or redirect, so the address stays stable while a request is outstanding.
- Accept on imem_ready in FETCH (no redirect in the same cycle):
  - pc <= pc+2 (mod 2^16).
  - {imem_rdata, pc+2} goes to the output register if it is empty or being consumed this cycle and the skid is empty; otherwise it goes to the skid.
- Drain: when the output register is consumed (or empty) and the skid is valid, the skid moves to the output register and the skid clears. Fetch order is always preserved.
- Zero-wait memory gives one instruction per cycle when stall=0. Latency is imem_ready edge to inst_valid=1: 1 cycle.
- Stall: the output register holds value. At most 2 instructions are buffered (output + skid). imem_req drops when the skid is full.
- Halt: an accepted word with imem_rdata[15:11]==HALT_OP is delivered normally, then state goes to HALTED. In HALTED, imem_req=0 and pc is frozen at halt address+2. Already-buffered instructions still drain.
- Redirect (redirect_valid=1), highest priority after rst:
  - inst_valid<=0, skid_valid<=0, pc<=redirect_pc.
  - Any imem_rdata returning that cycle is dropped.
  - If imem_req=1 and imem_ready=0 that cycle: latch current imem_addr into req_addr and go to DISCARD. Otherwise go to FETCH.
  - Redirect in HALTED leaves HALTED and goes to FETCH.
  - Redirect with stall=1: the flush wins.
- DISCARD:
  - imem_req=1, imem_addr=req_addr, so the outstanding request completes unchanged.
  - On imem_ready, data is dropped and state goes to FETCH. The redirect target is requested next cycle.
  - A further redirect in DISCARD updates pc only and stays in DISCARD.
- PC wrap: 16'hFFFE+2 = 16'h0000; no flag.

Test Plan:
1. Zero-wait memory (imem_ready=1 always), mem[0..6]=16'h4101, 16'h4202, 16'h4303, 16'h4404, stall=0 -> inst_out sequence 4101, 4202, 4303, 4404 on consecutive cycles starting cycle 1 after reset release; pc_plus2_out 0002, 0004, 0006, 0008.
2. 3-cycle memory latency -> imem_addr held at 16'h0000 for 3 cycles; inst_valid pulses once per 3 cycles; no duplicate or lost instruction.
3. stall=1 for 4 cycles with zero-wait memory -> inst_out frozen at 4101, skid captures 4202, imem_req=0 while skid full. On release, 4202 then 4303 follow with no gap or loss.
4. Redirect to 16'h0100 while a 3-cycle request at 16'h0004 is outstanding -> state DISCARD, imem_addr stays 16'h0004 until ready, that data never appears on inst_out. Next request is at 16'h0100; first valid output has pc_plus2_out=16'h0102.
5. Word 16'h0000 at address 16'h0006 -> delivered with pc_plus2_out=16'h0008, then halted=1 and imem_req=0 for 20+ cycles. redirect_valid with redirect_pc=16'h0020 clears halted and fetches 16'h0020.
6. rst asserted mid-stall with skid full -> next cycle inst_valid=0, halted=0, imem_addr=RESET_PC.
